// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and helpers for the sprite drawing stage.
//   - Colour constants used on the 3-bit vga_adapter colour bus.
//   - FSM state encoding for sprite_plotter.
//   - Number of legal positions per item kind.
//   - press_slot(): folds the six press positions onto four slots so the
//     press sweeps back and forth across the slots.
package sprite_pkg;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_PRESS = 3'b111;
    localparam logic [2:0] COL_GARB  = 3'b010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLOT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int PRESS_POSITIONS = 6;
    localparam int GARB_POSITIONS  = 4;

    // Positions 0..3 map straight through; 4 and 5 fold back to 2 and 1.
    // Out-of-range positions are rejected before this result is used.
    function automatic logic [2:0] press_slot(input logic [2:0] pos);
        if (pos <= 3'd3)
            return pos;
        else
            return 3'(3'd6 - pos);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// raster_counter: walks a W x H rectangle in raster order, px fastest.
// Ports:
//   clock, reset    : clock and synchronous active-high reset
//   clear           : force the counter back to pixel (0,0)
//   advance         : step to the next pixel (wraps after the last one)
//   px, py          : current pixel coordinates inside the rectangle
//   last            : current pixel is (W-1, H-1)
module raster_counter #(
    parameter int W = 16,
    parameter int H = 16,
    localparam int PXW = (W > 1) ? $clog2(W) : 1,
    localparam int PYW = (H > 1) ? $clog2(H) : 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clear,
    input  logic           advance,
    output logic [PXW-1:0] px,
    output logic [PYW-1:0] py,
    output logic           last
);

    logic row_end;
    logic col_end;

    assign row_end = (px == PXW'(W - 1));
    assign col_end = (py == PYW'(H - 1));
    assign last    = row_end && col_end;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            px <= '0;
            py <= '0;
        end else if (advance) begin
            if (row_end) begin
                px <= '0;
                py <= col_end ? '0 : py + PYW'(1);
            end else begin
                px <= px + PXW'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_plotter.sv
// sprite_plotter: draws or blanks one rectangular sprite for vga_adapter.
// A start strobe (accepted while busy=0) latches the item kind, erase flag
// and position; the block then emits one pixel per clock in raster order
// and finishes with a one-cycle done pulse.
// Ports:
//   clock, reset       : clock and synchronous active-high reset
//   start              : request strobe, ignored while busy=1
//   item               : 1 = press sprite, 0 = garbage sprite
//   erase              : 1 = paint black, 0 = paint the item colour
//   position           : press 0..5, garbage 0..3 (others are rejected)
//   x, y, colour, plot : registered pixel stream to vga_adapter
//   busy               : high from the first through the last plotted pixel
//   done               : one-cycle completion pulse (also for rejected requests)
module sprite_plotter
    import sprite_pkg::*;
#(
    parameter int SPRITE_W   = 16,
    parameter int SPRITE_H   = 16,
    parameter int SLOT_X0    = 8,
    parameter int SLOT_PITCH = 36,
    parameter int PRESS_Y    = 20,
    parameter int GARB_Y     = 80
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       item,
    input  logic       erase,
    input  logic [2:0] position,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int PXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int PYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    logic [1:0]     state_reg;
    logic [7:0]     x0_reg;
    logic [PXW-1:0] px;
    logic [PYW-1:0] py;
    logic           last;
    logic           row_end;

    // Request decode, evaluated directly from the inputs at accept time.
    logic       req_valid;
    logic [2:0] req_slot;
    logic [7:0] req_x0;
    logic [6:0] req_y0;
    logic [2:0] req_colour;

    always_comb begin
        req_valid = item ? (position < 3'(PRESS_POSITIONS))
                         : (position < 3'(GARB_POSITIONS));
        req_slot  = item ? press_slot(position) : position;
        req_x0    = 8'(SLOT_X0 + int'(req_slot) * SLOT_PITCH);
        req_y0    = item ? 7'(PRESS_Y) : 7'(GARB_Y);
        if (erase)
            req_colour = COL_BLACK;
        else
            req_colour = item ? COL_PRESS : COL_GARB;
    end

    // The counter holds the coordinates of the pixel currently on the
    // outputs; it sits at (0,0) outside PLOT so the first pixel is ready.
    raster_counter #(
        .W (SPRITE_W),
        .H (SPRITE_H)
    ) u_raster (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_reg != ST_PLOT),
        .advance (state_reg == ST_PLOT),
        .px      (px),
        .py      (py),
        .last    (last)
    );

    assign row_end = (px == PXW'(SPRITE_W - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            x0_reg    <= '0;
            x         <= '0;
            y         <= '0;
            colour    <= '0;
            plot      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_PLOT: begin
                    if (last) begin
                        state_reg <= ST_DONE;
                        plot      <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (row_end) begin
                        // Origin is kept latched so the row restart is
                        // immune to input changes mid-draw.
                        x <= x0_reg;
                        y <= y + 7'd1;
                    end else begin
                        x <= x + 8'd1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request, which gives
                    // back-to-back operation straight out of the DONE cycle.
                    state_reg <= ST_IDLE;
                    plot      <= 1'b0;
                    busy      <= 1'b0;
                    if (start) begin
                        if (req_valid) begin
                            state_reg <= ST_PLOT;
                            x0_reg    <= req_x0;
                            x         <= req_x0;
                            y         <= req_y0;
                            colour    <= req_colour;
                            plot      <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
